// File: rtl/high_bus_pkg.sv
// Shared types and constants for the high-width bus responder:
// FSM states, header field positions and the bus word width.
package high_bus_pkg;

    localparam int WORD_W     = 32;
    localparam int HDR_RW_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    function automatic logic hdr_is_write(input logic [WORD_W-1:0] word);
        return word[HDR_RW_BIT];
    endfunction

endpackage

// File: rtl/high_bus_responder_if.sv
// Word-stream bus between the UART bridge (master) and the responder (slave).
interface high_bus_responder_if;

    logic [high_bus_pkg::WORD_W-1:0] high_write_data;
    logic                            high_write_valid;
    logic [high_bus_pkg::WORD_W-1:0] high_read_data;
    logic                            high_read_valid;
    logic                            proto_err;

    modport master (
        output high_write_data,
        output high_write_valid,
        input  high_read_data,
        input  high_read_valid,
        input  proto_err
    );

    modport slave (
        input  high_write_data,
        input  high_write_valid,
        output high_read_data,
        output high_read_valid,
        output proto_err
    );

endinterface

// File: rtl/high_bus_mem.sv
// Word memory for the responder: one synchronous write port, one
// combinational read port, storage is never reset.
module high_bus_mem
    import high_bus_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [DEPTH_LOG-1:0] i_waddr,
    input  logic [WORD_W-1:0]    i_wdata,
    input  logic [DEPTH_LOG-1:0] i_raddr,
    output logic [WORD_W-1:0]    o_rdata
);

    logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_LOG)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/high_bus_responder.sv
// Decodes header words from the bridge into fixed-length read/write bursts
// against an internal word memory and streams read bursts back.
module high_bus_responder
    import high_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int BRUST_SIZE_LOG = 2,
    parameter int MEM_DEPTH_LOG  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    high_bus_responder_if.slave  bus
);

    if (MEM_DEPTH_LOG > ADDR_WIDTH) begin : g_bad_depth
        $error("MEM_DEPTH_LOG must not exceed ADDR_WIDTH");
    end

    localparam logic [BRUST_SIZE_LOG-1:0] LAST_BEAT = '1;
    localparam logic [BRUST_SIZE_LOG-1:0] BEAT_ONE  = 1;
    localparam logic [MEM_DEPTH_LOG-1:0]  ADDR_ONE  = 1;

    state_t                    r_state;
    logic [MEM_DEPTH_LOG-1:0]  r_addr;
    logic [BRUST_SIZE_LOG-1:0] r_beat;
    logic [WORD_W-1:0]         r_rdata;
    logic                      r_rvalid;
    logic                      r_proto_err;

    logic [MEM_DEPTH_LOG-1:0]  w_hdr_idx;
    logic [MEM_DEPTH_LOG-1:0]  w_raddr;
    logic [WORD_W-1:0]         w_mem_rdata;
    logic                      w_we;

    // Only the low address bits index memory, so wrap-around is free.
    assign w_hdr_idx = bus.high_write_data[MEM_DEPTH_LOG-1:0];
    assign w_raddr   = (r_state == ST_RDATA) ? r_addr : w_hdr_idx;
    assign w_we      = (r_state == ST_WDATA) && bus.high_write_valid;

    high_bus_mem #(
        .DEPTH_LOG (MEM_DEPTH_LOG)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (bus.high_write_data),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_beat      <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.high_write_valid) begin
                        r_beat <= '0;
                        if (hdr_is_write(bus.high_write_data)) begin
                            r_addr  <= w_hdr_idx;
                            r_state <= ST_WDATA;
                        end else begin
                            // First beat is launched straight from the header cycle.
                            r_rdata  <= w_mem_rdata;
                            r_rvalid <= 1'b1;
                            r_addr   <= w_hdr_idx + ADDR_ONE;
                            r_state  <= ST_RDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus.high_write_valid) begin
                        r_addr <= r_addr + ADDR_ONE;
                        r_beat <= r_beat + BEAT_ONE;
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (bus.high_write_valid) begin
                        r_proto_err <= 1'b1;
                    end
                    // r_beat counts beats already launched, minus one.
                    if (r_beat == LAST_BEAT) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rdata  <= w_mem_rdata;
                        r_rvalid <= 1'b1;
                        r_addr   <= r_addr + ADDR_ONE;
                        r_beat   <= r_beat + BEAT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.high_read_data  = r_rdata;
    assign bus.high_read_valid = r_rvalid;
    assign bus.proto_err       = r_proto_err;

endmodule
